osc_freq_meter: RTL
===================

Name: osc_freq_meter

Overview:
- Synchronous measurement block for a free-running gated oscillator.
- Drives the oscillator's `enable`, samples its asynchronous output, and counts rising edges over a fixed gate window of system-clock cycles.
- Reports the edge count, an overflow flag and a stuck (no-oscillation) flag.
- Sits between the oscillator macro and the lab's display/readout logic.

Parameters:
- SETTLE_CYCLES, 16: clk cycles the oscillator runs before counting starts. Must be ≥1.
- GATE_CYCLES, 1000: length of the measurement window in clk cycles. Must be ≥1.
- CNT_W, 16: width of edge_count.
- SYNC_STAGES, 2: flip-flop stages in the osc_in synchronizer. Must be ≥2.

Ports:
- clk  input  1  system clock; all logic is on its rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a measurement; sampled only in IDLE
- osc_in  input  1  oscillator output, asynchronous to clk
- osc_enable  output  1  drives the oscillator enable
- busy  output  1  high in ARM and MEASURE
- done  output  1  one-cycle pulse when a result is valid
- edge_count  output  CNT_W  rising edges counted in the last window
- overflow  output  1  edge_count saturated during the last window
- stuck  output  1  last window counted zero edges

Behaviour:
- Reset (synchronous, evaluated at the clk edge):
  - FSM goes to IDLE.
  - osc_enable=0, busy=0, done=0, edge_count=0, overflow=0, stuck=0.
  - Synchronizer flops, previous-sample flop and internal timer are cleared to 0.
  - Reset asserted mid-measurement aborts the run: osc_enable=0 from the next cycle, no done pulse.
- Synchronizer and edge detect:
  - osc_in passes through SYNC_STAGES flops, then one previous-sample flop.
  - rise = sync_out & ~prev.
  - A rise pulse occurs SYNC_STAGES+1 clk edges after osc_in goes high.
  - Correct counting requires the osc_in high and low phases each to be ≥1 clk period plus setup. Faster inputs alias; this is not flagged.
- FSM states, with registered outputs per state:
  - IDLE: osc_enable=0, busy=0. If start=1, load timer=SETTLE_CYCLES-1 and go to ARM. On entry to ARM, clear edge_count, overflow and stuck.
  - ARM: osc_enable=1, busy=1. Timer decrements each cycle. At timer=0, load timer=GATE_CYCLES-1 and go to MEASURE. Rises are ignored. ARM lasts exactly SETTLE_CYCLES cycles.
  - MEASURE: osc_enable=1, busy=1. Each cycle with rise=1 increments edge_count. At all-ones, edge_count holds and overflow is set, sticky until the next start. At timer=0, go to DONE; a rise on that last cycle is still counted. MEASURE lasts exactly GATE_CYCLES cycles.
  - DONE: osc_enable=0, busy=0, done=1 for exactly one cycle. stuck=(edge_count==0). Then go to IDLE.
- start is ignored in ARM, MEASURE and DONE. A start held high re-triggers on the first IDLE cycle after DONE.
- Latency: start sampled at edge k. busy and osc_enable go high after edge k. done is high in the cycle after edge k+SETTLE_CYCLES+GATE_CYCLES+1.
- edge_count, overflow and stuck hold their values in IDLE until the next accepted start.
- Timer width is the ceiling of log2(max(SETTLE_CYCLES, GATE_CYCLES)), minimum 1.

Test Plan:
- Reset behaviour: assert reset for 3 cycles with osc_in toggling → all outputs 0, FSM in IDLE, no done.
- Nominal count: clk 10 ns, osc_in 40 ns square wave, defaults except GATE_CYCLES=100. Pulse start → done after 117 cycles, edge_count=25±1, overflow=0, stuck=0, osc_enable high for exactly 116 cycles.
- Stuck oscillator: osc_in held at 0 (or 1), start → done with edge_count=0, stuck=1.
- Saturation: CNT_W=4, GATE_CYCLES=100, osc_in 40 ns → edge_count=15, overflow=1. A following run with osc_in at 200 ns period → overflow=0, edge_count=5±1.
- start while busy: pulse start again mid-MEASURE → ignored, exactly one done pulse. start held high → back-to-back runs with one IDLE cycle between done pulses.
- Reset mid-MEASURE: assert reset at cycle 50 of the window → osc_enable=0 next cycle, no done, edge_count=0. A later start measures normally.

Source files
------------

// File: rtl/osc_freq_meter.sv
// Gated-oscillator frequency meter: enables the oscillator, lets it settle,
// then counts synchronized rising edges of osc_in over a fixed clk window.
module osc_freq_meter #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned GATE_CYCLES   = 1000,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             osc_in,
    output logic             osc_enable,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_count,
    output logic             overflow,
    output logic             stuck
);

    localparam int unsigned MAX_CYC = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]             state, state_nxt;
    logic [TMR_W-1:0]       timer, timer_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;
    logic [CNT_W-1:0]       count_nxt;
    logic                   ov_nxt, stuck_nxt, done_nxt, run_nxt;

    // Only the oscillator output is asynchronous; everything downstream sees sync_q
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            osc_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            edge_count <= '0;
            overflow   <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], osc_in};
            prev_q     <= sync_q[SYNC_STAGES-1];
            osc_enable <= run_nxt;
            busy       <= run_nxt;
            done       <= done_nxt;
            edge_count <= count_nxt;
            overflow   <= ov_nxt;
            stuck      <= stuck_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        count_nxt = edge_count;
        ov_nxt    = overflow;
        stuck_nxt = stuck;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ARM;
                    timer_nxt = TMR_W'(SETTLE_CYCLES - 1);
                    count_nxt = '0;
                    ov_nxt    = 1'b0;
                    stuck_nxt = 1'b0;
                end
            end
            S_ARM: begin
                if (timer == '0) begin
                    state_nxt = S_MEAS;
                    timer_nxt = TMR_W'(GATE_CYCLES - 1);
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
            S_MEAS: begin
                // Saturate rather than wrap so a too-fast oscillator reads as full scale
                if (rise) begin
                    if (edge_count == {CNT_W{1'b1}}) begin
                        ov_nxt = 1'b1;
                    end else begin
                        count_nxt = edge_count + CNT_W'(1);
                    end
                end
                if (timer == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    timer_nxt = timer - TMR_W'(1);
                end
            end
            S_DONE: begin
                done_nxt  = 1'b1;
                stuck_nxt = (edge_count == '0);
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        run_nxt = (state_nxt == S_ARM) || (state_nxt == S_MEAS);
    end

endmodule
